// File: rtl/timer_mc_pkg.sv
// Shared constants for the multi-channel timer: register offsets and bit positions in
// the control and status registers.
package timer_mc_pkg;

    localparam logic [1:0] TDR_OFS  = 2'd0;
    localparam logic [1:0] TCR_OFS  = 2'd1;
    localparam logic [1:0] TSR_OFS  = 2'd2;
    localparam logic [1:0] TCNT_OFS = 2'd3;

    localparam int unsigned TCR_W      = 10;
    localparam int unsigned TCR_CKS_LO = 0;
    localparam int unsigned TCR_CKS_HI = 2;
    localparam int unsigned TCR_EN     = 4;
    localparam int unsigned TCR_DN     = 5;
    localparam int unsigned TCR_ARL    = 6;
    localparam int unsigned TCR_LOAD   = 7;
    localparam int unsigned TCR_OVF_IE = 8;
    localparam int unsigned TCR_UDF_IE = 9;

    // Bit 3 has no function; it always reads 0.
    localparam logic [TCR_W-1:0] TCR_MASK = 10'h3F7;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

endpackage

// File: rtl/timer_mc_ch.sv
// One timer channel: holds TDR/TCR/TSR/TCNT, performs load/count/reload and raises the
// channel's interrupt from its sticky flags.
module timer_mc_ch
    import timer_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       tick,
    input  logic             wr_tdr,
    input  logic             wr_tcr,
    input  logic             wr_tsr,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] tdr,
    output logic [TCR_W-1:0] tcr,
    output logic [1:0]       tsr,
    output logic [CNT_W-1:0] tcnt,
    output logic             irq
);

    logic [CNT_W-1:0] tdr_q, tdr_d;
    logic [TCR_W-1:0] tcr_q, tcr_d;
    logic [1:0]       tsr_q, tsr_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             cnt_tick;
    logic             ovf_set, udf_set;
    logic [1:0]       tsr_clr;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        tdr_d    = wr_tdr ? wdata[CNT_W-1:0] : tdr_q;
        tcr_d    = wr_tcr ? (wdata[TCR_W-1:0] & TCR_MASK) : tcr_q;
        tcnt_d   = tcnt_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        cnt_tick = tcr_q[TCR_EN] & tick[tcr_q[TCR_CKS_HI:TCR_CKS_LO]];

        if (tcr_q[TCR_LOAD]) begin
            tcnt_d = tdr_q;
        end else if (cnt_tick && !tcr_q[TCR_DN]) begin
            if (&tcnt_q) begin
                tcnt_d  = tcr_q[TCR_ARL] ? tdr_q : '0;
                ovf_set = 1'b1;
            end else begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
        end else if (cnt_tick && tcr_q[TCR_DN]) begin
            if (tcnt_q == '0) begin
                tcnt_d  = tcr_q[TCR_ARL] ? tdr_q : '1;
                udf_set = 1'b1;
            end else begin
                tcnt_d = tcnt_q - CNT_W'(1);
            end
        end

        // A flag being set on the same edge as its W1C clear stays set.
        tsr_clr = wr_tsr ? wdata[1:0] : 2'b00;
        tsr_d   = (tsr_q & ~tsr_clr) | {udf_set, ovf_set};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tdr_q  <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            tcnt_q <= '0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign tdr  = tdr_q;
    assign tcr  = tcr_q;
    assign tsr  = tsr_q;
    assign tcnt = tcnt_q;
    assign irq  = (tsr_q[TSR_OVF] & tcr_q[TCR_OVF_IE]) | (tsr_q[TSR_UDF] & tcr_q[TCR_UDF_IE]);

endmodule

// File: rtl/timer_mc.sv
// Multi-channel APB timer: shared prescaler, APB decode and read mux around NUM_CH
// independent timer_mc_ch channels.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    logic [7:0]  div_cnt_q;
    logic [7:0]  tick;
    logic [3:0]  ch_sel;
    logic [1:0]  ofs;
    logic        access;
    logic        ch_valid;
    logic [31:0] rd_mux;
    logic [31:0] ch_rdata [NUM_CH];
    logic        unused_paddr;

    assign unused_paddr = ^paddr[1:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_tick
        assign tick[k] = &div_cnt_q[k:0];
    end

    assign ch_sel   = paddr[7:4];
    assign ofs      = paddr[3:2];
    assign access   = psel & penable;
    assign ch_valid = 32'(ch_sel) < NUM_CH;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             wr_ch;
        logic [CNT_W-1:0] tdr, tcnt;
        logic [TCR_W-1:0] tcr;
        logic [1:0]       tsr;

        assign wr_ch = access & pwrite & (ch_sel == 4'(i));

        timer_mc_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .tick    (tick),
            .wr_tdr  (wr_ch && ofs == TDR_OFS),
            .wr_tcr  (wr_ch && ofs == TCR_OFS),
            .wr_tsr  (wr_ch && ofs == TSR_OFS),
            .wdata   (pwdata),
            .tdr     (tdr),
            .tcr     (tcr),
            .tsr     (tsr),
            .tcnt    (tcnt),
            .irq     (irq[i])
        );

        assign ch_rdata[i] = (ofs == TDR_OFS) ? 32'(tdr) :
                             (ofs == TCR_OFS) ? 32'(tcr) :
                             (ofs == TSR_OFS) ? 32'(tsr) : 32'(tcnt);
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 4'(i)) begin
                rd_mux = ch_rdata[i];
            end
        end
    end

    assign prdata  = (access && !pwrite) ? rd_mux : '0;
    assign pready  = 1'b1;
    assign pslverr = access & ~ch_valid;
    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_mc.sv
// Directed self-checking bench for timer_mc (NUM_CH = 4, CNT_W = 16).
module tb_timer_mc;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              psel, penable, pwrite;
    logic [7:0]        paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    timer_mc #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge sys_clk);
        #1 psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge sys_clk);
        #1 penable = 1'b1;
        @(posedge sys_clk);
        #1 bus_idle();
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(posedge sys_clk);
        #1 psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge sys_clk);
        #1 penable = 1'b1;
        #3 d = prdata; e = pslverr;
        @(posedge sys_clk);
        #1 bus_idle();
    endtask

    task automatic hold_read(input logic [7:0] a);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    endtask

    logic [31:0] d;
    logic        e;
    logic        found;
    int          t0;
    logic [31:0] prev, a0, a3, b0, b3;
    logic [15:0] diff;

    initial begin
        bus_idle();
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        chk("por_irq", 32'(irq), 32'h0);
        chk("pready", 32'(pready), 32'h1);

        // Reset asserted while channel 2 is counting.
        apb_write(8'h20, 32'h1234);
        apb_write(8'h24, 32'h013);
        repeat (100) @(posedge sys_clk);
        apb_read(8'h2C, d, e);
        chk("ch2_counting", {31'b0, d != 32'h0}, 32'h1);
        #3 sys_rst = 1'b1;
        hold_read(8'h2C);
        #1 chk("tcnt_async_rst", prdata, 32'h0);
        chk("irq_in_rst", 32'(irq), 32'h0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0; bus_idle();
        for (int ch = 0; ch < 4; ch++) begin
            for (int o = 0; o < 4; o++) begin
                apb_read(8'(ch * 16 + o * 4), d, e);
                chk($sformatf("rst_reg_ch%0d_ofs%0d", ch, o * 4), d, 32'h0);
            end
        end
        repeat (40) @(posedge sys_clk);
        apb_read(8'h2C, d, e);
        chk("ch2_stopped", d, 32'h0);
        chk("irq_after_rst", 32'(irq), 32'h0);
        chk("irq_any_after_rst", 32'(irq_any), 32'h0);
        apb_read(8'h40, d, e);
        chk("bad_ch_rdata", d, 32'h0);
        chk("bad_ch_slverr", 32'(e), 32'h1);
        apb_read(8'h04, d, e);
        chk("good_ch_slverr", 32'(e), 32'h0);

        // Channel 0 down-count underflow, cks = 2.
        apb_write(8'h00, 32'h0005);
        apb_write(8'h04, 32'h080);
        apb_write(8'h04, 32'h032);
        t0 = cyc;
        repeat (30) @(posedge sys_clk);
        apb_read(8'h08, d, e);
        chk("udf_early", d, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apb_read(8'h08, d, e);
            if (d[1]) begin
                found = 1'b1;
                break;
            end
        end
        chk("udf_set", 32'(found), 32'h1);
        chk("udf_not_before_41", {31'b0, (cyc - t0) >= 41}, 32'h1);
        chk("udf_by_56", {31'b0, (cyc - t0) <= 56}, 32'h1);
        apb_read(8'h0C, d, e);
        chk("udf_wrap_ffff", d, 32'h0000FFFF);
        apb_write(8'h04, 32'h0);
        apb_write(8'h08, 32'h3);
        apb_read(8'h08, d, e);
        chk("tsr0_w1c", d, 32'h0);

        // Channel 1 auto-reload up-count, cks = 0.
        apb_write(8'h10, 32'hFFFD);
        apb_write(8'h14, 32'h080);
        apb_write(8'h14, 32'h150);
        t0 = cyc;
        hold_read(8'h1C);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
            if (irq[1]) begin
                found = 1'b1;
                break;
            end
        end
        chk("ovf_irq1", 32'(found), 32'h1);
        chk("arl_tcnt_fffd", prdata, 32'h0000FFFD);
        chk("ovf_irq_any", 32'(irq_any), 32'h1);
        chk("ovf_after_3_ticks", {31'b0, (cyc - t0) >= 5 && (cyc - t0) <= 6}, 32'h1);
        bus_idle();
        apb_write(8'h14, 32'h140);
        chk("ovf_sticky", 32'(irq[1]), 32'h1);
        apb_write(8'h18, 32'h1);
        chk("w1c_irq1", 32'(irq[1]), 32'h0);
        chk("w1c_irq_any", 32'(irq_any), 32'h0);

        // W1C committed on an overflow edge: the set wins.
        apb_write(8'h04, 32'h010);
        apb_write(8'h10, 32'hFFFF);
        apb_write(8'h14, 32'h190);
        apb_write(8'h14, 32'h150);
        hold_read(8'h0C);
        @(posedge sys_clk);
        #1 prev = prdata;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk);
            #1;
            if (prdata != prev) begin
                found = 1'b1;
                break;
            end
            prev = prdata;
        end
        chk("tick_phase_found", 32'(found), 32'h1);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h18; pwdata = 32'h1;
        @(posedge sys_clk);
        #1 penable = 1'b1;
        @(posedge sys_clk);
        #1 chk("set_wins_over_clr", 32'(irq[1]), 32'h1);
        @(posedge sys_clk);
        #1 chk("clr_off_tick", 32'(irq[1]), 32'h0);
        bus_idle();
        apb_write(8'h14, 32'h0);
        apb_write(8'h04, 32'h0);
        apb_write(8'h18, 32'h3);
        apb_write(8'h08, 32'h3);

        // Channel independence: ch0 up cks = 0, ch3 down cks = 7.
        apb_write(8'h00, 32'h1000);
        apb_write(8'h04, 32'h080);
        apb_write(8'h04, 32'h010);
        apb_write(8'h30, 32'h0100);
        apb_write(8'h34, 32'h080);
        apb_write(8'h34, 32'h037);
        @(posedge sys_clk);
        #1 hold_read(8'h0C);
        #1 a0 = prdata; paddr = 8'h3C;
        #1 a3 = prdata;
        repeat (512) @(posedge sys_clk);
        #1 paddr = 8'h0C;
        #1 b0 = prdata; paddr = 8'h3C;
        #1 b3 = prdata;
        bus_idle();
        diff = b0[15:0] - a0[15:0];
        chk("ch0_adv_256", 32'(diff), 32'd256);
        diff = a3[15:0] - b3[15:0];
        chk("ch3_adv_2", 32'(diff), 32'd2);
        for (int ch = 0; ch < 4; ch++) begin
            apb_read(8'(ch * 16 + 8), d, e);
            chk($sformatf("indep_tsr_ch%0d", ch), d, 32'h0);
        end
        chk("indep_irq", 32'(irq), 32'h0);
        apb_write(8'h04, 32'h0);
        apb_write(8'h34, 32'h0);

        // Load has priority over counting.
        apb_write(8'h20, 32'hFFFF);
        apb_write(8'h24, 32'h190);
        repeat (2) @(posedge sys_clk);
        hold_read(8'h2C);
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1 chk($sformatf("load_hold_%0d", i), prdata, 32'h0000FFFF);
        end
        bus_idle();
        apb_read(8'h28, d, e);
        chk("load_no_flags", d, 32'h0);
        chk("load_no_irq", 32'(irq), 32'h0);
        apb_read(8'h24, d, e);
        chk("tcr_readback", d, 32'h190);
        apb_write(8'h24, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
